// File: rtl/vram_pkg.sv
// Shared encodings and default geometry for the VRAM row-operation engine.
package vram_pkg;

   localparam int unsigned COLS_BITS_DEF = 6;
   localparam int unsigned ROWS_BITS_DEF = 5;
   localparam int unsigned DATA_W_DEF    = 9;

   typedef enum logic [1:0] {
      MODE_FILL        = 2'd0,
      MODE_SCROLL_UP   = 2'd1,
      MODE_SCROLL_DOWN = 2'd2,
      MODE_RSVD        = 2'd3
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_FILL = 3'd1,
      ST_RD   = 3'd2,
      ST_WR   = 3'd3,
      ST_DONE = 3'd4
   } state_e;

endpackage

// File: rtl/vram_addr_walker.sv
// Row/column cell walker shared by the copy and fill phases; exposes the
// position it will hold after this edge so the top can register its address.
module vram_addr_walker #(
   parameter int unsigned COLS_BITS = 6,
   parameter int unsigned ROWS_BITS = 5,
   parameter int unsigned ADDR_W    = COLS_BITS + ROWS_BITS
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load,
   input  logic              i_down,
   input  logic [ADDR_W-1:0] i_start_row,
   input  logic [ADDR_W-1:0] i_end_row,
   input  logic              i_step,
   output logic              o_last_cell,
   output logic [ADDR_W-1:0] o_nxt_dst_addr,
   output logic [ADDR_W-1:0] o_nxt_src_addr
);

   localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'((2 ** COLS_BITS) - 1);

   logic [ADDR_W-1:0]    r_row, r_col, r_end;
   logic                 r_down;
   logic [ADDR_W-1:0]    w_nxt_row, w_nxt_col, w_nxt_end;
   logic                 w_nxt_down;
   logic                 w_last_col;
   logic [ROWS_BITS-1:0] w_src_row;

   assign w_last_col  = (r_col == LAST_COL);
   assign o_last_cell = w_last_col && (r_row == r_end);

   always_comb begin
      w_nxt_row  = r_row;
      w_nxt_col  = r_col;
      w_nxt_end  = r_end;
      w_nxt_down = r_down;
      if (i_load) begin
         w_nxt_row  = i_start_row;
         w_nxt_col  = '0;
         w_nxt_end  = i_end_row;
         w_nxt_down = i_down;
      end else if (i_step) begin
         if (w_last_col) begin
            w_nxt_col = '0;
            w_nxt_row = r_down ? (r_row - ADDR_W'(1)) : (r_row + ADDR_W'(1));
         end else begin
            w_nxt_col = r_col + ADDR_W'(1);
         end
      end
   end

   // Source row is the neighbour opposite to the walk direction.
   assign w_src_row = ROWS_BITS'(w_nxt_down ? (w_nxt_row - ADDR_W'(1))
                                            : (w_nxt_row + ADDR_W'(1)));
   assign o_nxt_dst_addr = {w_nxt_row[ROWS_BITS-1:0], w_nxt_col[COLS_BITS-1:0]};
   assign o_nxt_src_addr = {w_src_row, w_nxt_col[COLS_BITS-1:0]};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_row  <= '0;
         r_col  <= '0;
         r_end  <= '0;
         r_down <= 1'b0;
      end else begin
         r_row  <= w_nxt_row;
         r_col  <= w_nxt_col;
         r_end  <= w_nxt_end;
         r_down <= w_nxt_down;
      end
   end

endmodule

// File: rtl/vram_blit.sv
// Row fill / scroll-up / scroll-down engine that owns the VRAM port while busy.
module vram_blit
   import vram_pkg::*;
#(
   parameter int unsigned COLS_BITS = COLS_BITS_DEF,
   parameter int unsigned ROWS_BITS = ROWS_BITS_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned ADDR_W    = COLS_BITS + ROWS_BITS
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic [1:0]           i_mode,
   input  logic [ROWS_BITS-1:0] i_first_row,
   input  logic [ROWS_BITS-1:0] i_last_row,
   input  logic [DATA_W-1:0]    i_fill,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [ADDR_W-1:0]    o_vram_addr,
   output logic                 o_vram_ce,
   output logic                 o_vram_w,
   output logic [DATA_W-1:0]    o_vram_din,
   input  logic [DATA_W-1:0]    i_vram_dout
);

   state_e               r_state, w_state_nxt;
   mode_e                r_mode;
   logic [ROWS_BITS-1:0] r_first, r_last;
   logic [DATA_W-1:0]    r_fill, w_fill_nxt, r_din, w_din_nxt;
   logic                 r_busy, r_done, r_ce, r_w;
   logic [ADDR_W-1:0]    r_addr, w_addr_nxt;

   logic                 w_load, w_down, w_step, w_last_cell;
   logic [ADDR_W-1:0]    w_start_row, w_end_row, w_nxt_dst, w_nxt_src;

   vram_addr_walker #(
      .COLS_BITS (COLS_BITS),
      .ROWS_BITS (ROWS_BITS),
      .ADDR_W    (ADDR_W)
   ) u_walker (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_load         (w_load),
      .i_down         (w_down),
      .i_start_row    (w_start_row),
      .i_end_row      (w_end_row),
      .i_step         (w_step),
      .o_last_cell    (w_last_cell),
      .o_nxt_dst_addr (w_nxt_dst),
      .o_nxt_src_addr (w_nxt_src)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_down      = 1'b0;
      w_step      = 1'b0;
      w_start_row = '0;
      w_end_row   = '0;
      w_fill_nxt  = r_fill;
      case (r_state)
         ST_IDLE: begin
            if (i_start && (i_mode != MODE_RSVD)) begin
               w_fill_nxt = i_fill;
               if (i_first_row > i_last_row) begin
                  w_state_nxt = ST_DONE;
               end else if ((i_mode == MODE_FILL) || (i_first_row == i_last_row)) begin
                  w_load      = 1'b1;
                  w_start_row = ADDR_W'(i_first_row);
                  w_end_row   = ADDR_W'(i_last_row);
                  w_state_nxt = ST_FILL;
               end else if (i_mode == MODE_SCROLL_UP) begin
                  w_load      = 1'b1;
                  w_start_row = ADDR_W'(i_first_row);
                  w_end_row   = ADDR_W'(i_last_row) - ADDR_W'(1);
                  w_state_nxt = ST_RD;
               end else begin
                  w_load      = 1'b1;
                  w_down      = 1'b1;
                  w_start_row = ADDR_W'(i_last_row);
                  w_end_row   = ADDR_W'(i_first_row) + ADDR_W'(1);
                  w_state_nxt = ST_RD;
               end
            end
         end
         ST_RD: w_state_nxt = ST_WR;
         ST_WR: begin
            // After the final copy, refill only the vacated row.
            if (w_last_cell) begin
               w_load      = 1'b1;
               w_start_row = (r_mode == MODE_SCROLL_DOWN) ? ADDR_W'(r_first) : ADDR_W'(r_last);
               w_end_row   = w_start_row;
               w_state_nxt = ST_FILL;
            end else begin
               w_step      = 1'b1;
               w_state_nxt = ST_RD;
            end
         end
         ST_FILL: begin
            if (w_last_cell) w_state_nxt = ST_DONE;
            else             w_step      = 1'b1;
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_addr_nxt = '0;
      w_din_nxt  = '0;
      case (w_state_nxt)
         ST_FILL: begin
            w_addr_nxt = w_nxt_dst;
            w_din_nxt  = w_fill_nxt;
         end
         ST_RD:   w_addr_nxt = w_nxt_src;
         ST_WR:   w_addr_nxt = w_nxt_dst;
         default: w_addr_nxt = '0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mode  <= MODE_FILL;
         r_first <= '0;
         r_last  <= '0;
         r_fill  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ce    <= 1'b0;
         r_w     <= 1'b0;
         r_addr  <= '0;
         r_din   <= '0;
      end else begin
         if ((r_state == ST_IDLE) && i_start) begin
            r_mode  <= mode_e'(i_mode);
            r_first <= i_first_row;
            r_last  <= i_last_row;
         end
         r_fill <= w_fill_nxt;
         r_busy <= (w_state_nxt == ST_FILL) || (w_state_nxt == ST_RD) || (w_state_nxt == ST_WR);
         r_ce   <= (w_state_nxt == ST_FILL) || (w_state_nxt == ST_RD) || (w_state_nxt == ST_WR);
         r_w    <= (w_state_nxt == ST_FILL) || (w_state_nxt == ST_WR);
         r_done <= (w_state_nxt == ST_DONE);
         r_addr <= w_addr_nxt;
         r_din  <= w_din_nxt;
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_vram_ce   = r_ce;
   assign o_vram_w    = r_w;
   assign o_vram_addr = r_addr;
   // Copy writes forward the read data that arrives in the WR cycle.
   assign o_vram_din  = (r_state == ST_WR) ? i_vram_dout : r_din;

endmodule

// File: tb/tb_vram_blit.sv
// Directed bench for vram_blit: vector table plus reset-abort and start-ignore sequences.
module tb_vram_blit;

   logic       clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_start = 1'b0;
   logic [1:0] i_mode = 2'd0;
   logic [4:0] i_first_row = '0;
   logic [4:0] i_last_row = '0;
   logic [8:0] i_fill = '0;
   logic       o_busy, o_done, o_vram_ce, o_vram_w;
   logic [10:0] o_vram_addr;
   logic [8:0] o_vram_din;
   logic [8:0] vram_dout = '0;

   always #5 clk = ~clk;

   vram_blit dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_start     (i_start),
      .i_mode      (i_mode),
      .i_first_row (i_first_row),
      .i_last_row  (i_last_row),
      .i_fill      (i_fill),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_vram_addr (o_vram_addr),
      .o_vram_ce   (o_vram_ce),
      .o_vram_w    (o_vram_w),
      .o_vram_din  (o_vram_din),
      .i_vram_dout (vram_dout)
   );

   // VRAM model: synchronous write, registered read data; preload sets row n to n.
   logic [8:0] mem [0:2047];
   logic [8:0] exp_mem [0:2047];
   logic       preload = 1'b0;

   always @(posedge clk) begin
      if (preload) begin
         for (int a = 0; a < 2048; a++) mem[a] <= 9'(a / 64);
      end else if (o_vram_ce) begin
         if (o_vram_w) mem[o_vram_addr] <= o_vram_din;
         else          vram_dout <= mem[o_vram_addr];
      end
   end

   // Bus monitor, sampled mid-cycle on the falling edge.
   logic [1:0]  cur_mode = 2'd0;
   logic [4:0]  cur_first = '0, cur_last = '0;
   logic [8:0]  cur_fill = '0;
   int n_busy = 0, n_done = 0, n_wr = 0, n_rd = 0;
   int n_range = 0, n_order = 0, n_seq = 0, n_din = 0;
   logic        p_rd = 1'b0, p_fw = 1'b0;
   logic [10:0] p_addr = '0;
   logic        m_rd, m_wr;
   logic [4:0]  m_row, m_src_row;
   logic [10:0] m_src_addr;

   assign m_rd       = o_vram_ce && !o_vram_w;
   assign m_wr       = o_vram_ce && o_vram_w;
   assign m_row      = o_vram_addr[10:6];
   assign m_src_row  = (cur_mode == 2'd2) ? (m_row - 5'd1) : (m_row + 5'd1);
   assign m_src_addr = {m_src_row, o_vram_addr[5:0]};

   always @(negedge clk) begin
      if (o_busy) n_busy <= n_busy + 1;
      if (o_done) n_done <= n_done + 1;
      if (m_wr) n_wr <= n_wr + 1;
      if (m_rd) n_rd <= n_rd + 1;
      if (o_vram_ce && ((m_row < cur_first) || (m_row > cur_last))) n_range <= n_range + 1;
      if ((o_vram_ce && !o_busy) || (p_rd && !m_wr) || (p_rd && m_wr && (p_addr != m_src_addr)))
         n_order <= n_order + 1;
      if (m_wr && !p_rd && (o_vram_din != cur_fill)) n_din <= n_din + 1;
      if (m_wr && !p_rd && (p_fw ? (o_vram_addr != 11'(p_addr + 11'd1)) : (o_vram_addr[5:0] != 6'd0)))
         n_seq <= n_seq + 1;
      p_rd   <= m_rd;
      p_fw   <= m_wr && !p_rd;
      p_addr <= o_vram_addr;
   end

   int n_cmp = 0, n_bad = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_preload();
      preload = 1'b1;
      @(posedge clk); #1;
      preload = 1'b0;
   endtask

   task automatic exp_preload();
      for (int a = 0; a < 2048; a++) exp_mem[a] = 9'(a / 64);
   endtask

   // Reference behaviour of one operation on the expected image.
   task automatic apply_model(input logic [1:0] m, input int f, input int l, input logic [8:0] fv);
      if ((m == 2'd3) || (f > l)) return;
      if (m == 2'd0) begin
         for (int r = f; r <= l; r++) for (int c = 0; c < 64; c++) exp_mem[r*64+c] = fv;
      end else if (m == 2'd1) begin
         for (int r = f; r < l; r++) for (int c = 0; c < 64; c++) exp_mem[r*64+c] = exp_mem[(r+1)*64+c];
         for (int c = 0; c < 64; c++) exp_mem[l*64+c] = fv;
      end else begin
         for (int r = l; r > f; r--) for (int c = 0; c < 64; c++) exp_mem[r*64+c] = exp_mem[(r-1)*64+c];
         for (int c = 0; c < 64; c++) exp_mem[f*64+c] = fv;
      end
   endtask

   task automatic check_mem(input string nm);
      int bad = 0;
      int first_bad = -1;
      for (int a = 0; a < 2048; a++) begin
         if (mem[a] !== exp_mem[a]) begin
            bad++;
            if (first_bad < 0) first_bad = a;
         end
      end
      if (bad != 0) $display("  first bad word at %0d: got %h want %h", first_bad, mem[first_bad], exp_mem[first_bad]);
      check({nm, "/mem_words_wrong"}, bad, 0);
   endtask

   task automatic wait_done(input int limit, output int lat);
      lat = 0;
      for (int c = 1; c <= limit; c++) begin
         if (o_done) begin
            lat = c;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic run_op(input string nm, input logic [1:0] m, input logic [4:0] f, input logic [4:0] l,
                         input logic [8:0] fv, input int e_wr, input int e_rd, input int e_busy,
                         input int e_lat, input int e_dn);
      int s_busy, s_done, s_wr, s_rd, s_range, s_err, lat;
      do_preload();
      exp_preload();
      apply_model(m, int'(f), int'(l), fv);
      cur_mode = m; cur_first = f; cur_last = l; cur_fill = fv;
      s_busy = n_busy; s_done = n_done; s_wr = n_wr; s_rd = n_rd;
      s_range = n_range; s_err = n_order + n_seq + n_din;
      i_mode = m; i_first_row = f; i_last_row = l; i_fill = fv; i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      wait_done((e_lat == 0) ? 8 : 5000, lat);
      repeat (2) begin @(posedge clk); #1; end
      check({nm, "/done_latency"}, lat, e_lat);
      check({nm, "/busy_cycles"}, n_busy - s_busy, e_busy);
      check({nm, "/write_cycles"}, n_wr - s_wr, e_wr);
      check({nm, "/read_cycles"}, n_rd - s_rd, e_rd);
      check({nm, "/done_pulses"}, n_done - s_done, e_dn);
      check({nm, "/out_of_range"}, n_range - s_range, 0);
      check({nm, "/bus_order_data"}, n_order + n_seq + n_din - s_err, 0);
      check_mem(nm);
   endtask

   typedef struct {
      logic [1:0] mode;
      logic [4:0] first;
      logic [4:0] last;
      logic [8:0] fill;
      int         wr;
      int         rd;
      int         busy;
      int         lat;
      int         dn;
   } vec_t;

   vec_t vecs [10];

   initial begin
      int lat, s_busy, s_done, s_wr, s_range, s_din, bad;

      //          mode  first  last   fill    wr    rd   busy   lat  done
      vecs[0] = '{2'd0, 5'd0,  5'd31, 9'h020, 2048, 0,   2048, 2049, 1};
      vecs[1] = '{2'd1, 5'd2,  5'd4,  9'h1AA, 192,  128, 320,  321,  1};
      vecs[2] = '{2'd2, 5'd29, 5'd31, 9'h155, 192,  128, 320,  321,  1};
      vecs[3] = '{2'd0, 5'd5,  5'd3,  9'h0FF, 0,    0,   0,    1,    1};
      vecs[4] = '{2'd2, 5'd5,  5'd3,  9'h0FF, 0,    0,   0,    1,    1};
      vecs[5] = '{2'd3, 5'd0,  5'd1,  9'h011, 0,    0,   0,    0,    0};
      vecs[6] = '{2'd1, 5'd31, 5'd31, 9'h033, 64,   0,   64,   65,   1};
      vecs[7] = '{2'd2, 5'd0,  5'd1,  9'h1C3, 128,  64,  192,  193,  1};
      vecs[8] = '{2'd1, 5'd30, 5'd31, 9'h0AB, 128,  64,  192,  193,  1};
      vecs[9] = '{2'd0, 5'd31, 5'd31, 9'h0C4, 64,   0,   64,   65,   1};

      repeat (3) @(posedge clk);
      #1;
      check("reset/busy", int'(o_busy), 0);
      check("reset/done", int'(o_done), 0);
      check("reset/ce", int'(o_vram_ce), 0);
      check("reset/w", int'(o_vram_w), 0);
      check("reset/addr", int'(o_vram_addr), 0);
      check("reset/din", int'(o_vram_din), 0);
      i_rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++)
         run_op($sformatf("vec%0d", i), vecs[i].mode, vecs[i].first, vecs[i].last, vecs[i].fill,
                vecs[i].wr, vecs[i].rd, vecs[i].busy, vecs[i].lat, vecs[i].dn);

      // Reset in cycle 50 of a scroll-up aborts with no done and no further accesses.
      do_preload();
      cur_mode = 2'd1; cur_first = 5'd2; cur_last = 5'd4; cur_fill = 9'h1AA;
      i_mode = 2'd1; i_first_row = 5'd2; i_last_row = 5'd4; i_fill = 9'h1AA; i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (49) @(posedge clk);
      #1;
      check("abort/busy_before_reset", int'(o_busy), 1);
      s_done = n_done;
      i_rst = 1'b1;
      @(posedge clk); #1;
      check("abort/outputs_after_reset",
            int'({o_busy, o_done, o_vram_ce, o_vram_w}) + int'(o_vram_addr) + int'(o_vram_din), 0);
      i_rst = 1'b0;
      bad = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (o_vram_ce || o_done || o_busy) bad++;
      end
      check("abort/quiet_after_reset", bad, 0);
      check("abort/no_done", n_done - s_done, 0);
      run_op("abort_then_fill7", 2'd0, 5'd7, 5'd7, 9'h0E7, 64, 0, 64, 65, 1);

      // Start while busy and in the done cycle is ignored; next idle cycle is accepted.
      do_preload();
      exp_preload();
      apply_model(2'd0, 0, 0, 9'h0A5);
      apply_model(2'd0, 8, 8, 9'h15A);
      cur_mode = 2'd0; cur_first = 5'd0; cur_last = 5'd8; cur_fill = 9'h0A5;
      s_busy = n_busy; s_wr = n_wr; s_range = n_range; s_din = n_din;
      i_mode = 2'd0; i_first_row = 5'd0; i_last_row = 5'd0; i_fill = 9'h0A5; i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      i_first_row = 5'd10; i_last_row = 5'd10; i_fill = 9'h1FF; i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      wait_done(200, lat);
      check("ignore/done_latency_after_busy_start", lat, 54);
      i_first_row = 5'd9; i_last_row = 5'd9; i_fill = 9'h1FF; i_start = 1'b1;
      @(posedge clk); #1;
      check("ignore/start_in_done_cycle", int'(o_busy), 0);
      i_first_row = 5'd8; i_last_row = 5'd8; i_fill = 9'h15A; cur_fill = 9'h15A;
      @(posedge clk); #1;
      i_start = 1'b0;
      check("ignore/start_in_idle_accepted", int'(o_busy), 1);
      wait_done(5000, lat);
      repeat (2) begin @(posedge clk); #1; end
      check("ignore/second_latency", lat, 65);
      check("ignore/busy_cycles", n_busy - s_busy, 128);
      check("ignore/write_cycles", n_wr - s_wr, 128);
      check("ignore/out_of_range", n_range - s_range, 0);
      check("ignore/fill_data", n_din - s_din, 0);
      check_mem("ignore");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/vram_blit.md
Name: vram_blit

Overview:
- Parametrised successor to the screen-clear engine: performs rectangular-row VRAM operations for the serial terminal.
- Operations: fill a row range with a constant, scroll a row range up one row, or scroll it down one row. The vacated row is filled with the constant.
- Sits between the terminal control FSM and the VRAM port mux. Owns the VRAM port while o_busy is high.

Parameters:
COLS_BITS, 6, log2 of columns per row (64 columns)
ROWS_BITS, 5, log2 of rows (32 rows)
DATA_W, 9, VRAM word width (char + attribute)
ADDR_W, COLS_BITS+ROWS_BITS, VRAM address width, derived; address = {row, col}

Ports:
i_clk  in  1  system clock; all state updates on rising edge
i_rst  in  1  synchronous reset, active-high
i_start  in  1  one-cycle request; sampled only when idle
i_mode  in  2  0=FILL, 1=SCROLL_UP, 2=SCROLL_DOWN, 3=reserved
i_first_row  in  ROWS_BITS  first row of range (inclusive)
i_last_row  in  ROWS_BITS  last row of range (inclusive)
i_fill  in  DATA_W  fill word
o_busy  out  1  operation in progress
o_done  out  1  one-cycle pulse at completion
o_vram_addr  out  ADDR_W  VRAM address
o_vram_ce  out  1  VRAM chip enable
o_vram_w  out  1  VRAM write enable
o_vram_din  out  DATA_W  VRAM write data
i_vram_dout  in  DATA_W  VRAM read data; valid the cycle after a read address is presented with ce=1, w=0

Behaviour:
- Reset: o_busy, o_done, o_vram_ce, o_vram_w = 0; o_vram_addr = 0; o_vram_din = 0; FSM = IDLE. Reset mid-operation aborts at that edge, with no o_done and no further VRAM accesses.
- i_start, i_mode, rows and i_fill are latched on the edge where i_start=1 in IDLE.
  - i_start while busy is ignored.
  - Mode 3 is ignored: FSM stays IDLE, no done.
- Invalid range (first > last) in modes 0-2: no VRAM access. Go to DONE directly; o_done pulses on the cycle after start.
- FSM states: IDLE, FILL, RD, WR, DONE.
- FILL mode: IDLE -> FILL.
  - One write per cycle (ce=1, w=1, din=fill), addresses {first,0} up to {last,max}.
  - After the last address -> DONE.
  - Total write cycles = (last-first+1) * 2^COLS_BITS.
- SCROLL_UP: for dst row r = first..last-1, source row r+1, column 0..max ascending.
  - RD cycle: addr={r+1,c}, ce=1, w=0.
  - WR cycle: addr={r,c}, ce=1, w=1, din=i_vram_dout.
  - This is 2 cycles per cell. After the copy, enter FILL on row last only.
- SCROLL_DOWN: dst row r = last down to first+1, source row r-1, same RD/WR pairing. Then FILL on row first only.
- first==last in a scroll mode: no copy; FILL that single row.
- DONE: one cycle. o_done=1, o_busy=0, ce=0. Then IDLE.
  - A new i_start is accepted in DONE? No: only in IDLE, i.e. the cycle after the done pulse.
- o_busy = 1 in FILL, RD, WR. It rises the cycle after i_start is sampled.
- ce=0 and w=0 in IDLE and DONE. din = 0 outside WR/FILL.
- Row/column counters are ADDR_W-wide; the last-column test is an explicit compare, with no reliance on wrap. Row 2^ROWS_BITS-1 must be handled without overflow.
- No VRAM access outside [first,last] rows ever occurs.

Decomposition:
- Shared package vram_pkg: mode encodings (MODE_FILL, MODE_SCROLL_UP, MODE_SCROLL_DOWN), state enumeration, default COLS_BITS/ROWS_BITS/DATA_W.
- One natural sub-module: vram_addr_walker. It holds the row/column counter with direction, start row and end row, and exposes cur_addr, src_addr and last_cell flags. Reused by copy and fill phases.

Test Plan:
- FILL rows 0..31, fill=9'h020 -> exactly 2048 writes, addr 0..2047 ascending, all din=9'h020, o_done one pulse, o_busy high 2048 cycles.
- SCROLL_UP rows 2..4 with row n preloaded to value n -> rows 2,3 hold 3,4; row 4 = fill; rows 1 and 5 untouched; 256 copy cycles + 64 fill cycles.
- SCROLL_DOWN rows 29..31 with row n = n -> rows 30,31 hold 29,30; row 29 = fill; RD address always precedes its WR by one cycle.
- first=5, last=3 (any mode) -> zero ce cycles, o_done the cycle after start; mode 3 -> no busy, no done.
- Reset asserted during SCROLL_UP at cycle 50 -> next edge all outputs 0, no o_done; new FILL rows 7..7 then completes in 64 write cycles.
- i_start pulsed while busy and in DONE cycle -> ignored; start in the following IDLE cycle accepted.
